udp_tx_arbiter: RTL and testbench



---
 rtl/udp_tx_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_udp_tx_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// udp_tx_arbiter : round-robin sharing of one UDP TX engine by two channels
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module udp_tx_arbiter #(
  parameter logic [15:0] IFG_CYCLES     = 16'd12,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4000,
  parameter logic [15:0] MAX_BYTES      = 16'd1472
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ch0_req,
  input  logic [15:0] i_ch0_byte_num,
  input  logic [47:0] i_ch0_des_mac,
  input  logic [31:0] i_ch0_des_ip,
  input  logic [31:0] i_ch0_data,
  output logic        o_ch0_grant,
  output logic        o_ch0_rd_en,
  output logic        o_ch0_done,
  output logic        o_ch0_err,
  input  logic        i_ch1_req,
  input  logic [15:0] i_ch1_byte_num,
  input  logic [47:0] i_ch1_des_mac,
  input  logic [31:0] i_ch1_des_ip,
  input  logic [31:0] i_ch1_data,
  output logic        o_ch1_grant,
  output logic        o_ch1_rd_en,
  output logic        o_ch1_done,
  output logic        o_ch1_err,
  output logic        o_tx_start_en,
  output logic [15:0] o_tx_byte_num,
  output logic [47:0] o_des_mac,
  output logic [31:0] o_des_ip,
  output logic [31:0] o_tx_data,
  input  logic        i_tx_req,
  input  logic        i_tx_done,
  output logic        o_busy,
  output logic        o_timeout_err
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_START = 4'b0010,
    S_WAIT  = 4'b0100,
    S_GAP   = 4'b1000
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_owner, w_owner_nxt;
  logic        r_last, w_last_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [1:0]  r_grant, w_grant_nxt;
  logic [1:0]  r_done, w_done_nxt;
  logic [1:0]  r_err, w_err_nxt;
  logic        r_start, w_start_nxt;
  logic        r_tout, w_tout_nxt;
  logic [15:0] r_byte_num, w_byte_num_nxt;
  logic [47:0] r_des_mac, w_des_mac_nxt;
  logic [31:0] r_des_ip, w_des_ip_nxt;

  logic        w_any;
  logic        w_pick;
  logic        w_len_ok;
  logic [15:0] w_len;
  logic [47:0] w_mac;
  logic [31:0] w_ip;

  // On a tie the channel that was not served last wins.
  assign w_any    = i_ch0_req | i_ch1_req;
  assign w_pick   = (i_ch0_req & i_ch1_req) ? ~r_last : i_ch1_req;
  assign w_len    = w_pick ? i_ch1_byte_num : i_ch0_byte_num;
  assign w_mac    = w_pick ? i_ch1_des_mac  : i_ch0_des_mac;
  assign w_ip     = w_pick ? i_ch1_des_ip   : i_ch0_des_ip;
  assign w_len_ok = (w_len != 16'd0) && (w_len <= MAX_BYTES);

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_last_nxt     = r_last;
    w_cnt_nxt      = r_cnt;
    w_grant_nxt    = r_grant;
    w_done_nxt     = 2'b00;
    w_err_nxt      = 2'b00;
    w_start_nxt    = r_start;
    w_tout_nxt     = r_tout;
    w_byte_num_nxt = r_byte_num;
    w_des_mac_nxt  = r_des_mac;
    w_des_ip_nxt   = r_des_ip;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_owner_nxt = w_pick;
          w_last_nxt  = w_pick;
          w_cnt_nxt   = 16'd0;
          if (w_len_ok) begin
            w_byte_num_nxt = w_len;
            w_des_mac_nxt  = w_mac;
            w_des_ip_nxt   = w_ip;
            w_grant_nxt    = w_pick ? 2'b10 : 2'b01;
            w_start_nxt    = 1'b1;
            w_state_nxt    = S_START;
          end else begin
            w_err_nxt   = w_pick ? 2'b10 : 2'b01;
            w_state_nxt = S_GAP;
          end
        end
      end
      S_START: begin
        if (r_cnt == 16'd1) begin
          w_start_nxt = 1'b0;
          w_cnt_nxt   = 16'd0;
          w_state_nxt = S_WAIT;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_WAIT: begin
        // tx_done takes priority over a coincident timeout
        if (i_tx_done) begin
          w_done_nxt  = r_owner ? 2'b10 : 2'b01;
          w_tout_nxt  = 1'b0;
          w_grant_nxt = 2'b00;
          w_cnt_nxt   = 16'd0;
          w_state_nxt = S_GAP;
        end else if (r_cnt == TIMEOUT_CYCLES - 16'd1) begin
          w_err_nxt   = r_owner ? 2'b10 : 2'b01;
          w_tout_nxt  = 1'b1;
          w_grant_nxt = 2'b00;
          w_cnt_nxt   = 16'd0;
          w_state_nxt = S_GAP;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_GAP: begin
        if (r_cnt == IFG_CYCLES - 16'd1) begin
          w_cnt_nxt   = 16'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 16'd0;
        w_grant_nxt = 2'b00;
        w_start_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_cnt      <= 16'd0;
      r_grant    <= 2'b00;
      r_done     <= 2'b00;
      r_err      <= 2'b00;
      r_start    <= 1'b0;
      r_tout     <= 1'b0;
      r_byte_num <= 16'd0;
      r_des_mac  <= 48'd0;
      r_des_ip   <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_last     <= w_last_nxt;
      r_cnt      <= w_cnt_nxt;
      r_grant    <= w_grant_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_start    <= w_start_nxt;
      r_tout     <= w_tout_nxt;
      r_byte_num <= w_byte_num_nxt;
      r_des_mac  <= w_des_mac_nxt;
      r_des_ip   <= w_des_ip_nxt;
    end
  end

  assign o_ch0_grant   = r_grant[0];
  assign o_ch1_grant   = r_grant[1];
  assign o_ch0_done    = r_done[0];
  assign o_ch1_done    = r_done[1];
  assign o_ch0_err     = r_err[0];
  assign o_ch1_err     = r_err[1];
  assign o_ch0_rd_en   = i_tx_req & ~r_owner & (r_state == S_WAIT);
  assign o_ch1_rd_en   = i_tx_req &  r_owner & (r_state == S_WAIT);
  assign o_tx_data     = ((r_state == S_START) || (r_state == S_WAIT)) ?
                         (r_owner ? i_ch1_data : i_ch0_data) : 32'd0;
  assign o_tx_start_en = r_start;
  assign o_tx_byte_num = r_byte_num;
  assign o_des_mac     = r_des_mac;
  assign o_des_ip      = r_des_ip;
  assign o_busy        = (r_state != S_IDLE);
  assign o_timeout_err = r_tout;

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_udp_tx_arbiter : randomized frames checked against a frame-level model
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_udp_tx_arbiter;
  localparam int IFG  = 12;
  localparam int TMO  = 4000;
  localparam int MAXB = 1472;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ch0_req = 1'b0, ch1_req = 1'b0;
  logic [15:0] ch0_byte_num = '0, ch1_byte_num = '0;
  logic [47:0] ch0_des_mac = '0, ch1_des_mac = '0;
  logic [31:0] ch0_des_ip = '0, ch1_des_ip = '0;
  logic [31:0] ch0_data = '0, ch1_data = '0;
  logic        ch0_grant, ch0_rd_en, ch0_done, ch0_err;
  logic        ch1_grant, ch1_rd_en, ch1_done, ch1_err;
  logic        tx_start_en, busy, timeout_err;
  logic [15:0] tx_byte_num;
  logic [47:0] des_mac;
  logic [31:0] des_ip, tx_data;
  logic        tx_req = 1'b0, tx_done = 1'b0;

  always #5 clk = ~clk;

  udp_tx_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_ch0_req(ch0_req), .i_ch0_byte_num(ch0_byte_num), .i_ch0_des_mac(ch0_des_mac),
    .i_ch0_des_ip(ch0_des_ip), .i_ch0_data(ch0_data),
    .o_ch0_grant(ch0_grant), .o_ch0_rd_en(ch0_rd_en), .o_ch0_done(ch0_done), .o_ch0_err(ch0_err),
    .i_ch1_req(ch1_req), .i_ch1_byte_num(ch1_byte_num), .i_ch1_des_mac(ch1_des_mac),
    .i_ch1_des_ip(ch1_des_ip), .i_ch1_data(ch1_data),
    .o_ch1_grant(ch1_grant), .o_ch1_rd_en(ch1_rd_en), .o_ch1_done(ch1_done), .o_ch1_err(ch1_err),
    .o_tx_start_en(tx_start_en), .o_tx_byte_num(tx_byte_num), .o_des_mac(des_mac),
    .o_des_ip(des_ip), .o_tx_data(tx_data), .i_tx_req(tx_req), .i_tx_done(tx_done),
    .o_busy(busy), .o_timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Frame-level model state: who was served last, and the sticky timeout flag.
  bit m_last = 1'b1;
  bit m_tout = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic gap_phase();
    int cnt;
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      tx_req  = 1'($urandom_range(0, 1));
      tx_done = 1'($urandom_range(0, 1));
      #1;
      check("gap_rd", {ch1_rd_en, ch0_rd_en}, 2'b00);
      tick();
      check("gap_pulses", {ch1_done, ch0_done, ch1_err, ch0_err, tx_start_en}, 5'd0);
    end
    tx_req  = 1'b0;
    tx_done = 1'b0;
    check("gap_len", cnt, IFG);
  endtask

  // delay < 0 models an engine that never reports tx_done
  task automatic do_frame(input bit r0, input bit r1, input logic [15:0] l0,
                          input logic [15:0] l1, input int delay, input bit hold);
    bit          win, ok;
    logic [15:0] len;
    logic [47:0] mac;
    logic [31:0] ip;
    int          cnt;
    win = (r0 && r1) ? ~m_last : r1;
    m_last = win;
    ch0_byte_num = l0;
    ch1_byte_num = l1;
    ch0_des_mac  = {16'($urandom), $urandom};
    ch1_des_mac  = {16'($urandom), $urandom};
    ch0_des_ip   = $urandom;
    ch1_des_ip   = $urandom;
    len = win ? l1 : l0;
    mac = win ? ch1_des_mac : ch0_des_mac;
    ip  = win ? ch1_des_ip : ch0_des_ip;
    ok  = (len >= 1) && (len <= MAXB);
    ch0_req = r0;
    ch1_req = r1;
    tick();
    if (ok) begin
      check("grant", {ch1_grant, ch0_grant}, win ? 2'b10 : 2'b01);
      check("start_1", tx_start_en, 1'b1);
      check("byte_num", tx_byte_num, len);
      check("des_mac", des_mac, mac);
      check("des_ip", des_ip, ip);
      tick();
      check("start_2", tx_start_en, 1'b1);
      tick();
      check("start_off", tx_start_en, 1'b0);
      if (delay < 0) begin
        cnt = 0;
        while (!(ch0_err | ch1_err) && cnt < TMO + 10) begin
          tick();
          cnt++;
        end
        m_tout = 1'b1;
        check("tmo_latency", cnt, TMO);
        check("tmo_err", {ch1_err, ch0_err}, win ? 2'b10 : 2'b01);
        check("tmo_flag", timeout_err, m_tout);
        check("tmo_grant", {ch1_grant, ch0_grant}, 2'b00);
      end else begin
        for (int k = 0; k < delay; k++) begin
          tx_req   = 1'($urandom_range(0, 1));
          ch0_data = $urandom;
          ch1_data = $urandom;
          #1;
          check("rd_en", {ch1_rd_en, ch0_rd_en}, win ? {tx_req, 1'b0} : {1'b0, tx_req});
          check("tx_data", tx_data, win ? ch1_data : ch0_data);
          check("wait_quiet", {ch1_done, ch0_done, ch1_err, ch0_err}, 4'd0);
          tick();
        end
        tx_req  = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        m_tout  = 1'b0;
        check("done", {ch1_done, ch0_done}, win ? 2'b10 : 2'b01);
        check("done_err", {ch1_err, ch0_err}, 2'b00);
        check("done_grant", {ch1_grant, ch0_grant}, 2'b00);
        check("done_tout", timeout_err, m_tout);
        check("gap_len_hold", tx_byte_num, len);
      end
    end else begin
      check("rej_err", {ch1_err, ch0_err}, win ? 2'b10 : 2'b01);
      check("rej_grant", {ch1_grant, ch0_grant}, 2'b00);
      check("rej_start", tx_start_en, 1'b0);
      check("rej_tout", timeout_err, m_tout);
    end
    if (!hold) begin
      ch0_req = 1'b0;
      ch1_req = 1'b0;
    end
    gap_phase();
  endtask

  initial begin
    bit          r0, r1;
    logic [15:0] l0, l1;
    tick();
    tick();
    check("rst_outs", {ch0_grant, ch1_grant, ch0_done, ch1_done, ch0_err, ch1_err,
                       tx_start_en, busy, timeout_err}, 9'd0);
    check("rst_len", tx_byte_num, 16'd0);
    rst_n = 1'b1;
    tick();

    do_frame(1'b1, 1'b0, 16'd64, 16'd0, 117, 1'b0);

    // Both channels hold their requests across four frames
    for (int f = 0; f < 4; f++) do_frame(1'b1, 1'b1, 16'd100, 16'd200, 20, f != 3);

    do_frame(1'b0, 1'b1, 16'd0, 16'd0, 10, 1'b0);
    do_frame(1'b0, 1'b1, 16'd0, 16'd1473, 10, 1'b0);

    do_frame(1'b1, 1'b0, 16'd256, 16'd0, -1, 1'b0);
    do_frame(1'b1, 1'b0, 16'd300, 16'd0, 15, 1'b0);

    for (int f = 0; f < 30; f++) begin
      case ($urandom_range(0, 2))
        0:       begin r0 = 1'b1; r1 = 1'b0; end
        1:       begin r0 = 1'b0; r1 = 1'b1; end
        default: begin r0 = 1'b1; r1 = 1'b1; end
      endcase
      l0 = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 1) * (MAXB + 1 + $urandom_range(0, 500)))
                                       : 16'($urandom_range(1, MAXB));
      l1 = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 1) * (MAXB + 1 + $urandom_range(0, 500)))
                                       : 16'($urandom_range(1, MAXB));
      do_frame(r0, r1, l0, l1, int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)));
    end

    // Serve ch0 so that without a reset ch1 would win the next tie
    do_frame(1'b1, 1'b0, 16'd80, 16'd0, 5, 1'b0);
    ch0_req = 1'b1;
    ch0_byte_num = 16'd90;
    tick();
    tick();
    tick();
    tick();
    tx_req = 1'b1;
    rst_n  = 1'b0;
    #1;
    check("arst_outs", {ch0_grant, ch0_rd_en, ch1_rd_en, tx_start_en, busy, timeout_err}, 6'd0);
    check("arst_len", tx_byte_num, 16'd0);
    check("arst_data", tx_data, 32'd0);
    tick();
    tx_req  = 1'b0;
    ch0_req = 1'b0;
    rst_n   = 1'b1;
    m_last  = 1'b1;
    m_tout  = 1'b0;
    tick();
    do_frame(1'b1, 1'b1, 16'd50, 16'd60, 8, 1'b0);
    check("post_rst_last", m_last, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
